// File: rtl/rgb_luma_pipe_pkg.sv
// Mode encodings and the 8-fraction-bit coefficient table for the RGB-to-luma pipeline.
package rgb_luma_pipe_pkg;

   localparam logic [1:0] MODE_BT601 = 2'd0;
   localparam logic [1:0] MODE_BT709 = 2'd1;
   localparam logic [1:0] MODE_AVG   = 2'd2;
   localparam logic [1:0] MODE_GREEN = 2'd3;

   // Rows are {R, G, B}; 9 bits per entry so the green-only 256 fits. ch: 0=R, 1=G, 2=B.
   function automatic logic [8:0] base_coef(input logic [1:0] mode, input int ch);
      logic [26:0] row;
      row = '0;
      case (mode)
         MODE_BT601: row = {9'd77, 9'd150, 9'd29};
         MODE_BT709: row = {9'd54, 9'd183, 9'd19};
         MODE_AVG:   row = {9'd85, 9'd85,  9'd86};
         MODE_GREEN: row = {9'd0,  9'd256, 9'd0};
      endcase
      return row[(2 - ch) * 9 +: 9];
   endfunction

   function automatic int coef_scale(input int c, input int frac_w);
      return (frac_w >= 8) ? (c << (frac_w - 8)) : (c >> (8 - frac_w));
   endfunction

endpackage

// File: rtl/luma_coef_sel.sv
// Maps a coefficient mode to three FRAC_W+1-bit weights that always sum to 2^FRAC_W.
module luma_coef_sel
   import rgb_luma_pipe_pkg::*;
#(
   parameter int FRAC_W = 8
) (
   input  logic [1:0]      mode,
   output logic [FRAC_W:0] coef_r,
   output logic [FRAC_W:0] coef_g,
   output logic [FRAC_W:0] coef_b
);

   localparam int CW = FRAC_W + 1;
   localparam logic [CW-1:0] UNITY = CW'(1) << FRAC_W;

   always_comb begin
      coef_r = CW'(coef_scale(32'(base_coef(mode, 0)), FRAC_W));
      coef_b = CW'(coef_scale(32'(base_coef(mode, 2)), FRAC_W));
      // green absorbs any scaling truncation so unity gain is exact
      coef_g = UNITY - coef_r - coef_b;
   end

endmodule

// File: rtl/rgb_luma_pipe.sv
// RGB to luma converter: three-stage valid/ready pipeline (input, products, round/saturate)
// with a per-frame luma-sum accumulator on the consumed output stream.
module rgb_luma_pipe
   import rgb_luma_pipe_pkg::*;
#(
   parameter int IN_W   = 12,
   parameter int OUT_W  = 8,
   parameter int FRAC_W = 8,
   parameter int SUM_W  = 28
) (
   input  logic              iCLK,
   input  logic              iReset,
   input  logic [IN_W-1:0]   iRed,
   input  logic [IN_W-1:0]   iGreen,
   input  logic [IN_W-1:0]   iBlue,
   input  logic              iDval,
   input  logic              iSof,
   input  logic              iEof,
   output logic              oReady,
   input  logic [1:0]        iMode,
   output logic [OUT_W-1:0]  oGray,
   output logic              oDval,
   output logic              oSof,
   output logic              oEof,
   input  logic              iReady,
   output logic [SUM_W-1:0]  oFrameSum,
   output logic              oFrameDone
);

   localparam int CW = FRAC_W + 1;
   localparam int PW = IN_W + FRAC_W + 1;
   localparam int SW = PW + 2;
   localparam int SH = FRAC_W + IN_W - OUT_W;
   localparam logic [SW-1:0] HALF = SW'(1) << (SH - 1);
   localparam logic [SW-1:0] MAXY = (SW'(1) << OUT_W) - SW'(1);

   logic ld0, ld1, ld2, accept, consume;
   logic [1:0] mode_q, mode_d, pix_mode;

   logic s0_v_q, s0_v_d, s0_sof_q, s0_sof_d, s0_eof_q, s0_eof_d;
   logic [1:0] s0_mode_q, s0_mode_d;
   logic [IN_W-1:0] s0_r_q, s0_r_d, s0_g_q, s0_g_d, s0_b_q, s0_b_d;
   logic [CW-1:0] coef_r, coef_g, coef_b;

   logic s1_v_q, s1_v_d, s1_sof_q, s1_sof_d, s1_eof_q, s1_eof_d;
   logic [PW-1:0] s1_pr_q, s1_pr_d, s1_pg_q, s1_pg_d, s1_pb_q, s1_pb_d;
   logic [SW-1:0] sum_rnd, y_full;

   logic s2_v_q, s2_v_d, s2_sof_q, s2_sof_d, s2_eof_q, s2_eof_d;
   logic [OUT_W-1:0] s2_y_q, s2_y_d;

   logic [SUM_W-1:0] acc_q, acc_d, acc_base, acc_tot, fsum_q, fsum_d;
   logic [SUM_W:0]   acc_sum;
   logic done_q, done_d;

   luma_coef_sel #(.FRAC_W(FRAC_W)) u_coef_sel (
      .mode   (s0_mode_q),
      .coef_r (coef_r),
      .coef_g (coef_g),
      .coef_b (coef_b)
   );

   always_comb begin
      ld2      = ~s2_v_q | iReady;
      ld1      = ~s1_v_q | ld2;
      ld0      = ~s0_v_q | ld1;
      accept   = iDval & ld0;
      consume  = s2_v_q & iReady;
      pix_mode = iSof ? iMode : mode_q;

      sum_rnd = SW'(s1_pr_q) + SW'(s1_pg_q) + SW'(s1_pb_q) + HALF;
      y_full  = sum_rnd >> SH;

      acc_base = s2_sof_q ? '0 : acc_q;
      acc_sum  = (SUM_W+1)'(acc_base) + (SUM_W+1)'(s2_y_q);
      acc_tot  = acc_sum[SUM_W] ? '1 : acc_sum[SUM_W-1:0];

      mode_d    = mode_q;
      s0_v_d    = s0_v_q;    s0_sof_d = s0_sof_q;  s0_eof_d = s0_eof_q;
      s0_mode_d = s0_mode_q; s0_r_d   = s0_r_q;    s0_g_d   = s0_g_q;   s0_b_d = s0_b_q;
      s1_v_d    = s1_v_q;    s1_sof_d = s1_sof_q;  s1_eof_d = s1_eof_q;
      s1_pr_d   = s1_pr_q;   s1_pg_d  = s1_pg_q;   s1_pb_d  = s1_pb_q;
      s2_v_d    = s2_v_q;    s2_sof_d = s2_sof_q;  s2_eof_d = s2_eof_q; s2_y_d = s2_y_q;
      acc_d     = acc_q;     fsum_d   = fsum_q;    done_d   = 1'b0;

      if (accept && iSof) mode_d = iMode;

      if (ld0) begin
         s0_v_d = iDval;
         if (iDval) begin
            s0_r_d    = iRed;  s0_g_d   = iGreen; s0_b_d = iBlue;
            s0_sof_d  = iSof;  s0_eof_d = iEof;
            s0_mode_d = pix_mode;
         end
      end

      if (ld1) begin
         s1_v_d = s0_v_q;
         if (s0_v_q) begin
            s1_pr_d  = PW'(coef_r) * PW'(s0_r_q);
            s1_pg_d  = PW'(coef_g) * PW'(s0_g_q);
            s1_pb_d  = PW'(coef_b) * PW'(s0_b_q);
            s1_sof_d = s0_sof_q;
            s1_eof_d = s0_eof_q;
         end
      end

      if (ld2) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            s2_y_d   = (y_full > MAXY) ? '1 : y_full[OUT_W-1:0];
            s2_sof_d = s1_sof_q;
            s2_eof_d = s1_eof_q;
         end
      end

      // an oSof pixel restarts the total; an oEof pixel publishes it and clears
      if (consume) begin
         if (s2_eof_q) begin
            fsum_d = acc_tot;
            done_d = 1'b1;
            acc_d  = '0;
         end else begin
            acc_d  = acc_tot;
         end
      end
   end

   always_ff @(posedge iCLK or posedge iReset) begin
      if (iReset) begin
         mode_q    <= MODE_BT601;
         s0_v_q    <= 1'b0; s0_sof_q <= 1'b0; s0_eof_q <= 1'b0; s0_mode_q <= MODE_BT601;
         s0_r_q    <= '0;   s0_g_q   <= '0;   s0_b_q   <= '0;
         s1_v_q    <= 1'b0; s1_sof_q <= 1'b0; s1_eof_q <= 1'b0;
         s1_pr_q   <= '0;   s1_pg_q  <= '0;   s1_pb_q  <= '0;
         s2_v_q    <= 1'b0; s2_sof_q <= 1'b0; s2_eof_q <= 1'b0; s2_y_q <= '0;
         acc_q     <= '0;   fsum_q   <= '0;   done_q   <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         s0_v_q    <= s0_v_d;  s0_sof_q <= s0_sof_d; s0_eof_q <= s0_eof_d; s0_mode_q <= s0_mode_d;
         s0_r_q    <= s0_r_d;  s0_g_q   <= s0_g_d;   s0_b_q   <= s0_b_d;
         s1_v_q    <= s1_v_d;  s1_sof_q <= s1_sof_d; s1_eof_q <= s1_eof_d;
         s1_pr_q   <= s1_pr_d; s1_pg_q  <= s1_pg_d;  s1_pb_q  <= s1_pb_d;
         s2_v_q    <= s2_v_d;  s2_sof_q <= s2_sof_d; s2_eof_q <= s2_eof_d; s2_y_q <= s2_y_d;
         acc_q     <= acc_d;   fsum_q   <= fsum_d;   done_q   <= done_d;
      end
   end

   assign oReady     = ld0;
   assign oGray      = s2_y_q;
   assign oDval      = s2_v_q;
   assign oSof       = s2_sof_q;
   assign oEof       = s2_eof_q;
   assign oFrameSum  = fsum_q;
   assign oFrameDone = done_q;

endmodule
